keypad_scan: RTL
================

# keypad_scan

Scans a 4x4 matrix keypad, debounces presses and releases, and keeps the two most recent hex key codes for the dual seven-segment display. It sits directly upstream of the time-multiplexed display top. `digit_new`/`digit_old` replace the two switch nibbles as the display's right/left digit sources.

## Interface
- `SCAN_CYCLES`, default 50000: clock cycles each column is driven; minimum 3.
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required to accept a press or a release; minimum 1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rows`  in  4  keypad row lines, active-low, asynchronous, externally pulled up.
- `cols`  out  4  keypad column drive, active-low one-hot.
- `digit_new`  out  4  code of most recently accepted key.
- `digit_old`  out  4  code of the key accepted before that.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.

## Operation
- `rows` pass through a two-flop synchronizer. All decisions use the synchronized value `rows_s`.
- Key map (row r, col c → code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states:
  - SCAN:
    - Drive column `col_idx` for SCAN_CYCLES cycles.
    - On the last dwell cycle, sample `rows_s`. If any bit is low, latch the lowest-index low row as `row_idx`, clear the counter, and go to PRESS_DB.
    - Otherwise advance `col_idx` (3 wraps to 0) and restart the dwell.
  - PRESS_DB:
    - Column frozen.
    - While `rows_s[row_idx]`=0, increment the counter. When the count reaches DEBOUNCE_CYCLES, accept the key: `digit_old`←`digit_new`, `digit_new`←code, pulse `key_valid`, go to HOLD.
    - If `rows_s[row_idx]`=1 first, the press is a bounce: no output change, advance `col_idx`, go to SCAN.
  - HOLD:
    - Column frozen.
    - When `rows_s[row_idx]`=1, clear the counter and go to REL_DB.
  - REL_DB:
    - While `rows_s[row_idx]`=1, increment the counter. At DEBOUNCE_CYCLES, advance `col_idx` and go to SCAN.
    - If `rows_s[row_idx]`=0 first, return to HOLD with no output change.
- Simultaneous keys:
  - Only the first detected key is registered.
  - Other rows in the frozen column, and all keys in other columns, are ignored until the release completes.
  - A key still held at return to SCAN is detected again only if it remains low through a full new debounce. Holding two keys and releasing one therefore registers the other once.
- Counters saturate at their terminal values and never wrap. Counter width is `$clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)+1)`.

## Timing
- Reset values:
  - `cols`=4'b1110 (col 0)
  - `col_idx`=0
  - `digit_new`=0, `digit_old`=0
  - `key_valid`=0
  - state SCAN, counters 0
  - synchronizer flops 4'b1111
- Reset asserted in any state returns to the above on the next edge. It discards any press in progress.
- `cols` is registered and changes on the edge after the dwell ends.
- Row-to-decision latency is 2 cycles (synchronizer).
- Press acceptance: `key_valid` is high for exactly the cycle in which `digit_new`/`digit_old` first show the new values. That is the cycle after the DEBOUNCE_CYCLES-th stable cycle.
- Worst-case detection delay: 4·SCAN_CYCLES + 2 + DEBOUNCE_CYCLES + 1 cycles.
- `key_valid` fires at most once per press/release cycle.

## Structure
- Package `keypad_pkg` holds:
  - the `state_t` enum (SCAN, PRESS_DB, HOLD, REL_DB)
  - the `KEYMAP[4][4]` 4-bit constant array
  - a `col_onehot_n(idx)` function returning the active-low drive
- One sub-module, `sync2`: a parameterized-width two-flop synchronizer with reset value input.
- FSM, counters and digit registers live in `keypad_scan`.

## Test plan
Use SCAN_CYCLES=4 and DEBOUNCE_CYCLES=8. The bench keypad model drives `rows` low for a pressed key only while its column is driven low.
- Reset, no keys → `cols` cycles 1110→1101→1011→0111→1110 every 4 cycles; `key_valid` never asserts; digits 0/0.
- Press r1c2 (key 6), held 40 cycles, then release → one `key_valid` pulse; `digit_new`=6, `digit_old`=0. Press r3c1 (key 0) → `digit_new`=0, `digit_old`=6.
- Press key 5 for 5 cycles only (bounce) → no `key_valid`; digits unchanged; scanning resumes at the next column.
- Hold key A; glitch rows high for 3 cycles; hold 20 more cycles; release → exactly one `key_valid`; `digit_new`=A.
- Hold key 1, press key 9 after acceptance, release key 1, keep 9 held → first pulse with `digit_new`=1. After REL_DB and the rescan, a second pulse with `digit_new`=9, `digit_old`=1.
- Assert `reset` mid-PRESS_DB on key 3 → next cycle `cols`=1110, digits 0/0, no `key_valid`.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map and column drive.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StPressDb,
    StHold,
    StRelDb
  } state_t;

  // Indexed [row][col]; codes as printed on the keypad legend.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] col_onehot_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, with a caller-supplied reset value.
module sync2 #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] rst_val_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= rst_val_i;
      sync_q <= rst_val_i;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce; keeps the last two accepted key codes.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] rows_i,
  output logic [3:0] cols_o,
  output logic [3:0] digit_new_o,
  output logic [3:0] digit_old_o,
  output logic       key_valid_o
);

  localparam int unsigned MaxCycles = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                      : DEBOUNCE_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_CYCLES - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(MaxCycles);

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      col_idx_q;
  logic [1:0]      row_idx_q;
  logic [3:0]      cols_q;
  logic [3:0]      digit_new_q;
  logic [3:0]      digit_old_q;
  logic            key_valid_q;

  logic [3:0]      rows_s;
  logic [CntW-1:0] cnt_inc;
  logic [1:0]      col_nxt;
  logic [1:0]      first_row;
  logic            any_low;
  logic            row_hi;

  sync2 #(
    .Width (4)
  ) u_sync2 (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rst_val_i (4'b1111),
    .d_i       (rows_i),
    .q_o       (rows_s)
  );

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  assign col_nxt = col_idx_q + 2'd1;
  assign any_low = ~&rows_s;
  assign row_hi  = rows_s[row_idx_q];

  // Lowest-index low row wins when several rows are pulled down in the same column.
  always_comb begin
    first_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s[i]) first_row = 2'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StScan;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cols_q      <= 4'b1110;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (cnt_q == ScanLast) begin
            cnt_q <= '0;
            if (any_low) begin
              row_idx_q <= first_row;
              state_q   <= StPressDb;
            end else begin
              col_idx_q <= col_nxt;
              cols_q    <= col_onehot_n(col_nxt);
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StPressDb: begin
          if (!row_hi) begin
            if (cnt_q == DebLast) begin
              digit_old_q <= digit_new_q;
              digit_new_q <= KEYMAP[row_idx_q][col_idx_q];
              key_valid_q <= 1'b1;
              state_q     <= StHold;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            // Bounce: abandon this key and move on as if the column were empty.
            cnt_q     <= '0;
            col_idx_q <= col_nxt;
            cols_q    <= col_onehot_n(col_nxt);
            state_q   <= StScan;
          end
        end
        StHold: begin
          if (row_hi) begin
            cnt_q   <= '0;
            state_q <= StRelDb;
          end
        end
        StRelDb: begin
          if (row_hi) begin
            if (cnt_q == DebLast) begin
              cnt_q     <= '0;
              col_idx_q <= col_nxt;
              cols_q    <= col_onehot_n(col_nxt);
              state_q   <= StScan;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            state_q <= StHold;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  assign cols_o      = cols_q;
  assign digit_new_o = digit_new_q;
  assign digit_old_o = digit_old_q;
  assign key_valid_o = key_valid_q;

endmodule
